mips_muldiv: RTL and testbench
==============================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port start_i  input  1  request a MULT/MULTU/DIV/DIVU operation.
REQ-005 SHALL have port funct_i  input  6  operation select, of type funct_t from mips_pkg.
REQ-006 SHALL have port rs_data_i  input  32  multiplicand/dividend, and write data for MTHI/MTLO.
REQ-007 SHALL have port rt_data_i  input  32  multiplier/divisor.
REQ-008 SHALL have port mthi_i  input  1  write rs_data_i to HI.
REQ-009 SHALL have port mtlo_i  input  1  write rs_data_i to LO.
REQ-010 SHALL have port busy_o  output  1  operation in progress; the pipeline stalls on MFHI/MFLO while it is high.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse marking that HI/LO were just updated by an operation.
REQ-012 SHALL have port hi_o  output  32  HI register.
REQ-013 SHALL have port lo_o  output  32  LO register.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE; busy_o=1 only in CALC, and done_o=1 only in DONE.
REQ-015 SHALL accept start_i in IDLE or DONE when funct_i is MULT, MULTU, DIV or DIVU; it SHALL capture operands and funct at that edge, enter CALC and clear the 5-bit step counter.
REQ-016 SHALL ignore start_i with any other funct_i value, leaving the state unchanged.
REQ-017 SHALL ignore start_i while in CALC; input changes during CALC SHALL NOT affect the result.
REQ-018 SHALL perform one radix-2 step per CALC cycle, exactly 32 steps: shift-add for multiply, restoring for divide, operating on operand magnitudes.
REQ-019 SHALL, on the 32nd CALC edge, load the sign-corrected result into HI/LO and go to DONE; DONE SHALL go to IDLE unless a new start is accepted.
REQ-020 SHALL produce results as 32 cycles of busy_o, with done_o in the next cycle and hi_o/lo_o already valid.
REQ-021 SHALL, for MULT/MULTU, produce the 64-bit signed/unsigned product {HI,LO}.
REQ-022 SHALL, for DIV/DIVU, produce LO=quotient and HI=remainder; for signed operation, quotient truncates toward zero, quotient sign = sign(rs) XOR sign(rt), and remainder sign = sign(rs).
REQ-023 SHALL, on divide by zero (signed or unsigned), produce LO=0xFFFFFFFF and HI=rs_data_i as captured.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-025 SHALL, on mthi_i/mtlo_i in IDLE or DONE, write HI/LO at the next edge; mthi_i and mtlo_i together SHALL write both.
REQ-026 SHALL ignore mthi_i/mtlo_i during CALC.
REQ-027 SHALL give start_i priority over mthi_i/mtlo_i asserted in the same cycle; the moves are dropped.
REQ-028 SHALL hold hi_o/lo_o stable except at the REQ-019 and REQ-025 edges.

Reset
REQ-029 SHALL, while rst_n=0 at an edge, set state=IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0 and counter=0.
REQ-030 SHALL, on reset during CALC, abort the operation with no HI/LO update and no done_o pulse.
REQ-031 SHALL accept start_i on the first edge with rst_n=1.

Structure
REQ-032 SHALL place in mips_pkg: muldiv_state_t (IDLE, CALC, DONE) and MULDIV_STEPS=32; funct_t and DATA_MEM_WIDTH SHALL be reused.
REQ-033 SHALL use one sub-module, mips_muldiv_signfix (combinational): operand absolute values and result negation/special-case selection.
REQ-034 SHALL use a single shared 64-bit shift register and 33-bit adder/subtractor for both multiply and divide.

Verification
REQ-035 SHALL cover MULT rs=0xFFFFFFFE, rt=3 -> busy_o 32 cycles, then done_o with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 SHALL cover DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, and DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-038 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 SHALL cover start_i and mthi_i=1 (rs=5) at the 10th CALC cycle, then rst_n=0 at the 20th -> no effect from the start/move, HI=LO=0, no done_o.
REQ-040 SHALL cover MTHI rs=0x1234 in IDLE -> HI=0x1234 the next cycle, LO unchanged; then back-to-back MULTU accepted during DONE -> second done_o exactly 33 cycles after the first.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS types and constants for the core and the multiply/divide unit.
package mips_pkg;

  localparam int unsigned DATA_MEM_WIDTH = 32;
  localparam int unsigned MULDIV_STEPS   = 32;
  localparam int unsigned STEP_CNT_W     = 5;

  typedef enum logic [5:0] {
    F_SLL   = 6'h00,
    F_JR    = 6'h08,
    F_MFHI  = 6'h10,
    F_MTHI  = 6'h11,
    F_MFLO  = 6'h12,
    F_MTLO  = 6'h13,
    F_MULT  = 6'h18,
    F_MULTU = 6'h19,
    F_DIV   = 6'h1A,
    F_DIVU  = 6'h1B,
    F_ADD   = 6'h20,
    F_ADDU  = 6'h21,
    F_SUB   = 6'h22,
    F_SUBU  = 6'h23,
    F_AND   = 6'h24,
    F_OR    = 6'h25,
    F_XOR   = 6'h26,
    F_NOR   = 6'h27,
    F_SLT   = 6'h2A,
    F_SLTU  = 6'h2B
  } funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_muldiv(funct_t f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_div(funct_t f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_signed_op(funct_t f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Operand magnitudes going into the iterative core and sign/special-case
// correction of the raw unsigned result coming out of it.
module mips_muldiv_signfix
  import mips_pkg::*;
#(
  parameter int unsigned W = DATA_MEM_WIDTH
) (
  input  funct_t           funct,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   raw,
  output logic [W-1:0]     abs_a,
  output logic [W-1:0]     abs_b,
  output logic [W-1:0]     res_hi,
  output logic [W-1:0]     res_lo
);

  logic             neg_a;
  logic             neg_b;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;

  always_comb begin
    neg_a  = is_signed_op(funct) && op_a[W-1];
    neg_b  = is_signed_op(funct) && op_b[W-1];
    abs_a  = neg_a ? W'(-op_a) : op_a;
    abs_b  = neg_b ? W'(-op_b) : op_b;
    prod   = (neg_a ^ neg_b) ? (2*W)'(-raw) : raw;
    quo    = (neg_a ^ neg_b) ? W'(-raw[W-1:0]) : raw[W-1:0];
    rem    = neg_a ? W'(-raw[2*W-1:W]) : raw[2*W-1:W];
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (is_div(funct)) begin
      // Divide by zero returns all-ones quotient and the dividend as remainder.
      if (op_b == '0) begin
        res_hi = op_a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on a
// shared 64-bit shift register and 33-bit adder/subtractor.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_MEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  funct_t                funct_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = W + 1;

  muldiv_state_t          state_q, state_d;
  logic [STEP_CNT_W-1:0]  cnt_q;
  logic [2*W-1:0]         acc_q, acc_step;
  logic [W-1:0]           op_a_q, op_b_q;
  funct_t                 funct_q;
  logic                   accept, move, last, mul_op;
  logic [AW-1:0]          add_a, add_b;
  logic [AW:0]            add_res;
  funct_t                 sf_funct;
  logic [W-1:0]           sf_a, sf_b, abs_a, abs_b, res_hi, res_lo;

  assign accept = start_i && is_muldiv(funct_i) && (state_q != CALC);
  assign move   = (mthi_i || mtlo_i) && (state_q != CALC) && !accept;
  assign last   = (cnt_q == STEP_CNT_W'(MULDIV_STEPS - 1));

  // Sign logic sees live operands on the accept cycle, captured ones after.
  assign sf_funct = accept ? funct_i   : funct_q;
  assign sf_a     = accept ? rs_data_i : op_a_q;
  assign sf_b     = accept ? rt_data_i : op_b_q;

  mips_muldiv_signfix #(.W(W)) u_signfix (
    .funct  (sf_funct),
    .op_a   (sf_a),
    .op_b   (sf_b),
    .raw    (acc_step),
    .abs_a  (abs_a),
    .abs_b  (abs_b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_op  = !is_div(funct_q);
    add_a   = mul_op ? {1'b0, acc_q[2*W-1:W]} : acc_q[2*W-1:W-1];
    add_b   = mul_op ? {1'b0, abs_a} : ~{1'b0, abs_b};
    add_res = {1'b0, add_a} + {1'b0, add_b} + (AW+1)'(!mul_op);
    if (mul_op) begin
      acc_step = acc_q[0] ? {add_res[W:0], acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    end else begin
      acc_step = add_res[AW] ? {add_res[W-1:0], acc_q[W-2:0], 1'b1}
                             : {acc_q[2*W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last)   state_d = DONE;
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d == CALC);
      done_o  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      funct_q <= F_SLL;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (accept) begin
      op_a_q  <= rs_data_i;
      op_b_q  <= rt_data_i;
      funct_q <= funct_i;
      cnt_q   <= '0;
      acc_q   <= is_div(funct_i) ? {W'(0), abs_a} : {W'(0), abs_b};
    end else if (state_q == CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end else if (move) begin
      if (mthi_i) hi_o <= rs_data_i;
      if (mtlo_i) lo_o <= rs_data_i;
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed vectors, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mips_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  funct_t      funct;
  logic [31:0] rs, rt;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mips_muldiv #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .funct_i   (funct),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .mthi_i    (mthi),
    .mtlo_i    (mtlo),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  typedef struct {
    funct_t      f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model written from the HI/LO arithmetic rules.
  function automatic logic [63:0] model(funct_t f, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    int     ia, ib, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = int'(a);
        ib = int'(b);
        q  = ia / ib;
        r  = ia % ib;
        return {32'(r), 32'(q)};
      end
      F_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic funct_t rand_op();
    case ($urandom_range(0, 3))
      0:       return F_MULT;
      1:       return F_MULTU;
      2:       return F_DIV;
      default: return F_DIVU;
    endcase
  endfunction

  // Called just after a negedge; returns just after the accepting edge's negedge.
  task automatic issue(input funct_t f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    funct = f;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
    funct = rand_op();
    rs    = $urandom;
    rt    = $urandom;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 60) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input funct_t f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int c, bc;
    issue(f, a, b);
    wait_done(c, bc);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_hilo"}, {hi, lo}, exp);
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
  endtask

  vec_t vecs[$];

  initial begin
    int c, bc;
    logic done_seen;
    logic [63:0] e;

    vecs.push_back('{F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{F_DIV,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});

    rst_n = 1'b0; start = 1'b0; funct = F_SLL; rs = '0; rt = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);

    // Start accepted on the very first edge out of reset.
    rst_n = 1'b1;
    issue(F_MULTU, 32'd3, 32'd4);
    check("first_edge_busy", 64'(busy), 64'd1);
    wait_done(c, bc);
    check("first_edge_hilo", {hi, lo}, 64'd12);
    exp_hi = 32'd0; exp_lo = 32'd12;

    foreach (vecs[i]) begin
      @(negedge clk);
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
    end

    // Non-muldiv funct with start is ignored.
    @(negedge clk);
    start = 1'b1; funct = F_ADD; rs = 32'h55; rt = 32'h66;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd0);
    check("ignored_start_hilo", {hi, lo}, {exp_hi, exp_lo});

    // MTHI in IDLE, then MTLO, then both together.
    mthi = 1'b1; rs = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", {hi, lo}, {32'h1234, exp_lo});
    exp_hi = 32'h1234;
    mtlo = 1'b1; rs = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", {hi, lo}, {exp_hi, 32'hABCD});
    mthi = 1'b1; mtlo = 1'b1; rs = 32'h77;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_idle", {hi, lo}, {32'h77, 32'h77});

    // Back-to-back MULTU: second start accepted in DONE.
    issue(F_MULTU, 32'd5, 32'd6);
    wait_done(c, bc);
    check("b2b_first_hilo", {hi, lo}, 64'd30);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(c, bc);
    check("b2b_done_spacing", 64'(c + 1), 64'd33);
    check("b2b_second_hilo", {hi, lo}, 64'h1_FFFF_FFFE);

    // Move in DONE writes HI.
    mthi = 1'b1; rs = 32'hCAFE;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_done", {hi, lo}, {32'hCAFE, 32'hFFFF_FFFE});

    // Start and move together: move is dropped.
    mtlo = 1'b1;
    issue(F_MULTU, 32'd9, 32'd9);
    mtlo = 1'b0;
    check("start_prio_busy", 64'(busy), 64'd1);
    wait_done(c, bc);
    check("start_prio_hilo", {hi, lo}, 64'd81);
    exp_hi = 32'd0; exp_lo = 32'd81;

    // Start+MTHI at the 10th CALC cycle, reset at the 20th.
    @(negedge clk);
    issue(F_MULT, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(negedge clk);
    start = 1'b1; funct = F_MULT; mthi = 1'b1; rs = 32'd5; rt = 32'd3;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check("calc_move_ignored", {hi, lo}, {exp_hi, exp_lo});
    repeat (8) @(negedge clk);
    check("calc_still_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state", {hi, lo, 30'd0, busy, done}, 96'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_hilo_zero", {hi, lo}, 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      funct_t f;
      logic [31:0] a, b;
      f = rand_op();
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom_range(0, 15);
        1:       b = 32'd0;
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      e = model(f, a, b);
      @(negedge clk);
      run_op($sformatf("rand%0d_%s_%h_%h", i, f.name(), a, b), f, a, b, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
